// File: rtl/qpl_client_pkg.sv
// rtl/qpl_client_pkg.sv - shared geometry, sequencer states and req/rep word helpers
package qpl_client_pkg;
    localparam int LINE_BYTE = 32;
    localparam int LINE_WORD = 4;
    localparam int BLOCK_D   = 128;
    localparam int UDATA_W   = 8;
    localparam int BLOCK_W   = $clog2(BLOCK_D);
    localparam int WORD_W    = $clog2(LINE_WORD);
    localparam int REQ_S     = BLOCK_D * LINE_BYTE;
    localparam int SZ_W      = $clog2(REQ_S) + 1;
    localparam int REQ_W     = UDATA_W + SZ_W;
    localparam int REP_W     = UDATA_W + 2 * BLOCK_W + 1;
    localparam int VADDR_W   = BLOCK_W + WORD_W;
    localparam int CNT_W     = VADDR_W + 1;

    localparam logic [BLOCK_W:0] SIZE_FAIL = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_REP,
        ST_ADDR,
        ST_DEALLOC,
        ST_WAIT_DREP,
        ST_DONE
    } state_t;

    function automatic logic [REQ_W-1:0] pack_req(input logic [UDATA_W-1:0] udata,
                                                  input logic [SZ_W-1:0]    bytes);
        return {udata, bytes};
    endfunction

    function automatic logic [REP_W-1:0] pack_rep(input logic [UDATA_W-1:0] udata,
                                                  input logic [BLOCK_W:0]   size_lines,
                                                  input logic [BLOCK_W-1:0] base);
        return {udata, size_lines, base};
    endfunction

    function automatic logic [UDATA_W-1:0] rep_udata(input logic [REP_W-1:0] rep);
        return rep[REP_W-1 -: UDATA_W];
    endfunction

    function automatic logic [BLOCK_W:0] rep_size(input logic [REP_W-1:0] rep);
        return rep[2*BLOCK_W:BLOCK_W];
    endfunction

    function automatic logic [BLOCK_W-1:0] rep_base(input logic [REP_W-1:0] rep);
        return rep[BLOCK_W-1:0];
    endfunction
endpackage

// File: rtl/qpl_client_seq_if.sv
// rtl/qpl_client_seq_if.sv - command, allocator and translator channels of one client
interface qpl_client_seq_if;
    import qpl_client_pkg::*;

    logic               i_cmd_vld;
    logic [SZ_W-1:0]    i_cmd_bytes;
    logic [UDATA_W-1:0] i_cmd_udata;
    logic               o_cmd_rdy;

    logic               o_req_alloc_vld;
    logic [REQ_W-1:0]   o_req_alloc_data;
    logic               i_req_alloc_rdy;
    logic               i_rep_alloc_vld;
    logic [REP_W-1:0]   i_rep_alloc_data;
    logic               o_rep_alloc_rdy;

    logic               o_req_dealloc_vld;
    logic [REP_W-1:0]   o_req_dealloc_data;
    logic               i_req_dealloc_rdy;
    logic               i_rep_dealloc_vld;
    logic [REP_W-1:0]   i_rep_dealloc_data;
    logic               o_rep_dealloc_rdy;

    logic               o_base_vld;
    logic [VADDR_W-1:0] o_base_data;
    logic [BLOCK_W-1:0] o_base_user;
    logic               o_base_last;
    logic               i_base_rdy;

    logic               o_done;
    logic               o_fail;
    logic [UDATA_W-1:0] o_done_udata;
    logic               o_busy;

    modport master (
        input  i_cmd_vld, i_cmd_bytes, i_cmd_udata,
        output o_cmd_rdy,
        output o_req_alloc_vld, o_req_alloc_data,
        input  i_req_alloc_rdy, i_rep_alloc_vld, i_rep_alloc_data,
        output o_rep_alloc_rdy,
        output o_req_dealloc_vld, o_req_dealloc_data,
        input  i_req_dealloc_rdy, i_rep_dealloc_vld, i_rep_dealloc_data,
        output o_rep_dealloc_rdy,
        output o_base_vld, o_base_data, o_base_user, o_base_last,
        input  i_base_rdy,
        output o_done, o_fail, o_done_udata, o_busy
    );

    modport slave (
        output i_cmd_vld, i_cmd_bytes, i_cmd_udata,
        input  o_cmd_rdy,
        input  o_req_alloc_vld, o_req_alloc_data,
        output i_req_alloc_rdy, i_rep_alloc_vld, i_rep_alloc_data,
        input  o_rep_alloc_rdy,
        input  o_req_dealloc_vld, o_req_dealloc_data,
        output i_req_dealloc_rdy, i_rep_dealloc_vld, i_rep_dealloc_data,
        input  o_rep_dealloc_rdy,
        input  o_base_vld, o_base_data, o_base_user, o_base_last,
        output i_base_rdy,
        input  o_done, o_fail, o_done_udata, o_busy
    );
endinterface

// File: rtl/qpl_burst_gen.sv
// rtl/qpl_burst_gen.sv - walks every word offset of one allocation on the base channel
module qpl_burst_gen
    import qpl_client_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BLOCK_W:0]   i_size_lines,
    input  logic [BLOCK_W-1:0] i_base,
    input  logic               i_rdy,
    output logic               o_vld,
    output logic [VADDR_W-1:0] o_data,
    output logic [BLOCK_W-1:0] o_user,
    output logic               o_last,
    output logic               o_done
);
    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last_cnt;
    logic             w_fire;

    // One extra counter bit lets a full block (2^VADDR_W beats) end without wrapping.
    assign w_last_cnt = CNT_W'(i_size_lines) * CNT_W'(LINE_WORD) - CNT_W'(1);

    assign o_vld  = r_active;
    assign o_data = r_cnt[VADDR_W-1:0];
    assign o_user = i_base;
    assign o_last = r_active && (r_cnt == w_last_cnt);
    assign w_fire = r_active && i_rdy;
    assign o_done = w_fire && o_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (w_fire) begin
            if (o_last) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/qpl_client_seq.sv
// rtl/qpl_client_seq.sv - single-channel alloc / address-walk / dealloc sequencer
module qpl_client_seq
    import qpl_client_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    qpl_client_seq_if.master io_bus
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [SZ_W-1:0]    r_bytes;
    logic [UDATA_W-1:0] r_udata;
    logic [REP_W-1:0]   r_rep;
    logic               r_fail;
    logic               w_cmd_bad;
    logic               w_rep_fail;
    logic               w_burst_start;
    logic               w_burst_done;

    assign w_cmd_bad     = (io_bus.i_cmd_bytes == '0) || (io_bus.i_cmd_bytes > SZ_W'(REQ_S));
    assign w_rep_fail    = (rep_size(io_bus.i_rep_alloc_data) == SIZE_FAIL);
    assign w_burst_start = (r_state == ST_WAIT_REP) && io_bus.i_rep_alloc_vld && !w_rep_fail;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (io_bus.i_cmd_vld)         w_state_nxt = w_cmd_bad ? ST_DONE : ST_REQ;
            ST_REQ:       if (io_bus.i_req_alloc_rdy)   w_state_nxt = ST_WAIT_REP;
            ST_WAIT_REP:  if (io_bus.i_rep_alloc_vld)   w_state_nxt = w_rep_fail ? ST_DONE : ST_ADDR;
            ST_ADDR:      if (w_burst_done)             w_state_nxt = ST_DEALLOC;
            ST_DEALLOC:   if (io_bus.i_req_dealloc_rdy) w_state_nxt = ST_WAIT_DREP;
            ST_WAIT_DREP: if (io_bus.i_rep_dealloc_vld) w_state_nxt = ST_DONE;
            ST_DONE:                                    w_state_nxt = ST_IDLE;
            default:                                    w_state_nxt = ST_IDLE;
        endcase
    end

    // r_fail is only observed in DONE; the successful path leaves it at 0 from the reply check.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_bytes <= '0;
            r_udata <= '0;
            r_rep   <= '0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && io_bus.i_cmd_vld) begin
                r_bytes <= io_bus.i_cmd_bytes;
                r_udata <= io_bus.i_cmd_udata;
                r_fail  <= w_cmd_bad;
            end
            if ((r_state == ST_WAIT_REP) && io_bus.i_rep_alloc_vld) begin
                r_rep  <= io_bus.i_rep_alloc_data;
                r_fail <= w_rep_fail;
            end
        end
    end

    assign io_bus.o_cmd_rdy          = (r_state == ST_IDLE);
    assign io_bus.o_req_alloc_vld    = (r_state == ST_REQ);
    assign io_bus.o_req_alloc_data   = pack_req(r_udata, r_bytes);
    assign io_bus.o_rep_alloc_rdy    = (r_state == ST_WAIT_REP);
    assign io_bus.o_req_dealloc_vld  = (r_state == ST_DEALLOC);
    assign io_bus.o_req_dealloc_data = r_rep;
    assign io_bus.o_rep_dealloc_rdy  = (r_state == ST_WAIT_DREP);
    assign io_bus.o_done             = (r_state == ST_DONE);
    assign io_bus.o_fail             = (r_state == ST_DONE) && r_fail;
    assign io_bus.o_done_udata       = r_udata;
    assign io_bus.o_busy             = (r_state != ST_IDLE);

    qpl_burst_gen u_burst (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (w_burst_start),
        .i_size_lines (rep_size(r_rep)),
        .i_base       (rep_base(r_rep)),
        .i_rdy        (io_bus.i_base_rdy),
        .o_vld        (io_bus.o_base_vld),
        .o_data       (io_bus.o_base_data),
        .o_user       (io_bus.o_base_user),
        .o_last       (io_bus.o_base_last),
        .o_done       (w_burst_done)
    );
endmodule
